obstacle_sequencer: RTL and testbench

// - Consumer side of the obstacle random-code generator. Turns the free-running

---
 rtl/obstacle_sequencer_pkg.sv | 22 ++
 rtl/obstacle_sequencer_delay_counter.sv | 36 +++
 rtl/obstacle_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_obstacle_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_sequencer_pkg.sv
// Shared definitions for the obstacle sequencer and the obstacle modules around it.
//   seq_state_e : FSM state encoding (3 bits)
//   COUNT_W     : width of the completed-obstacle counter
//   sat_inc     : saturating increment for the completed-obstacle counter
package obstacle_sequencer_pkg;

    localparam int COUNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_ACTIVE = 3'd4,
        ST_GAP    = 3'd5
    } seq_state_e;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/obstacle_sequencer_delay_counter.sv
// Loadable down-counter with a zero flag, shared by the WARMUP and GAP phases.
// Ports:
//   i_Clk, i_Rst   clock, synchronous active-high reset
//   i_Load         load i_Load_Val (wins over i_Dec)
//   i_Load_Val     value to load
//   i_Dec          decrement by one, sticks at zero
//   o_Zero         count is zero
module obstacle_sequencer_delay_counter #(
    parameter int W = 3
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic [W-1:0] i_Load_Val,
    input  logic         i_Dec,
    output logic         o_Zero
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_Load)
            cnt_d = i_Load_Val;
        else if (i_Dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign o_Zero = (cnt_q == '0);

endmodule

// File: rtl/obstacle_sequencer.sv
// Obstacle sequencer: turns the free-running LFSR code stream into an ordered
// series of obstacle launches, with range/repeat filtering, a forced pick after
// too many rejects, an inter-obstacle gap and a saturating completion count.
// Ports:
//   i_Clk, i_Rst       clock, synchronous active-high reset
//   i_Start, i_Stop    game start (IDLE only) / game stop (forces IDLE)
//   i_Code             LFSR code
//   o_Lfsr_Enable      LFSR enable, high in every non-IDLE state
//   o_Obstacle_Sel     selected obstacle, held between launches
//   o_Obstacle_Start   one-cycle launch strobe
//   i_Obstacle_Done    completion pulse from the active obstacle
//   o_Busy             high outside IDLE
//   o_Count            completed obstacles, saturating
module obstacle_sequencer
    import obstacle_sequencer_pkg::*;
#(
    parameter int NUM_BITS      = 3,
    parameter int NUM_OBSTACLES = 5,
    parameter int NO_REPEAT     = 1,
    parameter int WARMUP_CYCLES = 5,
    parameter int GAP_CYCLES    = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic                i_Stop,
    input  logic [NUM_BITS-1:0] i_Code,
    output logic                o_Lfsr_Enable,
    output logic [NUM_BITS-1:0] o_Obstacle_Sel,
    output logic                o_Obstacle_Start,
    input  logic                i_Obstacle_Done,
    output logic                o_Busy,
    output logic [COUNT_W-1:0]  o_Count
);

    localparam int DLY_MAX = (WARMUP_CYCLES > GAP_CYCLES) ? WARMUP_CYCLES : GAP_CYCLES;
    localparam int DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX);

    localparam logic [DLY_W-1:0]    WARMUP_LD = DLY_W'(WARMUP_CYCLES - 1);
    localparam logic [DLY_W-1:0]    GAP_LD    = (GAP_CYCLES > 0) ? DLY_W'(GAP_CYCLES - 1) : '0;
    localparam logic [NUM_BITS-1:0] NUM_OBS_C = NUM_BITS'(NUM_OBSTACLES);
    localparam logic [NUM_BITS-1:0] LAST_OBS  = NUM_BITS'(NUM_OBSTACLES - 1);

    seq_state_e          state_d, state_q;
    logic [NUM_BITS-1:0] sel_d, sel_q;
    logic [NUM_BITS-1:0] last_d, last_q;
    logic                last_vld_d, last_vld_q;
    logic [NUM_BITS-1:0] rej_d, rej_q;
    logic [COUNT_W-1:0]  count_d, count_q;
    logic                start_d, start_q;
    logic                busy_d, busy_q;
    logic                en_d, en_q;

    logic                dly_load, dly_dec, dly_zero;
    logic [DLY_W-1:0]    dly_val;
    logic                code_ok;
    logic [NUM_BITS-1:0] forced_sel;

    obstacle_sequencer_delay_counter #(.W(DLY_W)) u_dly (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Load     (dly_load),
        .i_Load_Val (dly_val),
        .i_Dec      (dly_dec),
        .o_Zero     (dly_zero)
    );

    always_comb begin
        code_ok = (i_Code < NUM_OBS_C) &&
                  ((NO_REPEAT == 0) || !last_vld_q || (i_Code != last_q));
        // Forced pick walks forward from the last launch so a stuck LFSR still
        // produces a varied sequence.
        if (!last_vld_q || (last_q == LAST_OBS)) forced_sel = '0;
        else                                     forced_sel = last_q + 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        rej_d      = rej_q;
        count_d    = count_q;
        dly_load   = 1'b0;
        dly_val    = '0;
        dly_dec    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    count_d    = '0;
                    last_vld_d = 1'b0;
                    dly_load   = 1'b1;
                    dly_val    = WARMUP_LD;
                    state_d    = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (dly_zero) begin
                    rej_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (code_ok) begin
                    sel_d      = i_Code;
                    last_d     = i_Code;
                    last_vld_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end else if (rej_q == '1) begin
                    // this is the 2^NUM_BITS-th consecutive reject
                    sel_d      = forced_sel;
                    last_d     = forced_sel;
                    last_vld_d = 1'b1;
                    state_d    = ST_LAUNCH;
                end else begin
                    rej_d = rej_q + 1'b1;
                end
            end
            ST_LAUNCH: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (i_Obstacle_Done) begin
                    count_d = sat_inc(count_q);
                    if (GAP_CYCLES == 0) begin
                        rej_d   = '0;
                        state_d = ST_SAMPLE;
                    end else begin
                        dly_load = 1'b1;
                        dly_val  = GAP_LD;
                        state_d  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (dly_zero) begin
                    rej_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Stop overrides the FSM; selection and count stay frozen for the menu.
        if (i_Stop) begin
            state_d    = ST_IDLE;
            sel_d      = sel_q;
            last_d     = last_q;
            last_vld_d = last_vld_q;
            count_d    = count_q;
            dly_load   = 1'b0;
            dly_dec    = 1'b0;
        end

        // Outputs are registered from the next state, so a stop on the edge that
        // would enter LAUNCH also kills the strobe.
        start_d = (state_d == ST_LAUNCH);
        busy_d  = (state_d != ST_IDLE);
        en_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
            rej_q      <= '0;
            count_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            rej_q      <= rej_d;
            count_q    <= count_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            en_q       <= en_d;
        end
    end

    assign o_Lfsr_Enable    = en_q;
    assign o_Obstacle_Sel   = sel_q;
    assign o_Obstacle_Start = start_q;
    assign o_Busy           = busy_q;
    assign o_Count          = count_q;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Directed bench for obstacle_sequencer (NUM_BITS=3, NUM_OBSTACLES=5,
// NO_REPEAT=1, WARMUP_CYCLES=5, GAP_CYCLES=4). Codes are driven directly.
module tb_obstacle_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, stop_i, done_i;
    logic [2:0] code;
    logic       lfsr_en, strobe, busy;
    logic [2:0] sel;
    logic [7:0] count;

    int n_cmp = 0;
    int n_err = 0;

    obstacle_sequencer #(
        .NUM_BITS(3), .NUM_OBSTACLES(5), .NO_REPEAT(1),
        .WARMUP_CYCLES(5), .GAP_CYCLES(4)
    ) dut (
        .i_Clk            (clk),
        .i_Rst            (rst),
        .i_Start          (start_i),
        .i_Stop           (stop_i),
        .i_Code           (code),
        .o_Lfsr_Enable    (lfsr_en),
        .o_Obstacle_Sel   (sel),
        .o_Obstacle_Start (strobe),
        .i_Obstacle_Done  (done_i),
        .o_Busy           (busy),
        .o_Count          (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // advance n rising edges, land 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input int lim, output int k);
        k = 0;
        while (!strobe && k < lim) begin
            step(1);
            k++;
        end
    endtask

    // from LAUNCH: go ACTIVE, then pulse done with the next code already set
    task automatic finish_obstacle(input logic [2:0] next_code);
        step(1);
        done_i = 1'b1;
        code   = next_code;
        step(1);
        done_i = 1'b0;
    endtask

    initial begin
        int k;
        int seen;
        int tmo;

        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; done_i = 1'b0; code = 3'd0;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_en", lfsr_en, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_sel", sel, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;

        seen = 0;
        for (int i = 0; i < 20; i++) begin
            code = 3'(i);
            step(1);
            seen = seen | strobe | lfsr_en | busy;
        end
        chk("idle_quiet", seen, 0);

        // start: busy next cycle, 5 warmup + 1 sample -> strobe 6 edges later
        start_i = 1'b1; code = 3'd2;
        step(1);
        start_i = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_en", lfsr_en, 1);
        wait_strobe(21, k);
        chk("first_launch_lat", k, 6);
        chk("first_sel", sel, 2);

        // done during LAUNCH is ignored; strobe is one cycle wide
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        chk("strobe_width", strobe, 0);
        chk("done_in_launch", count, 0);

        // done in ACTIVE -> count 1, then 4 gap cycles + sample -> strobe
        done_i = 1'b1; code = 3'd1;
        step(1);
        chk("count_after_done", count, 1);
        step(1);              // done still high in first GAP cycle: ignored
        done_i = 1'b0;
        wait_strobe(40, k);
        chk("gap_latency", k + 1, 5);
        chk("gap_done_ignored", count, 1);
        chk("gap_sel", sel, 1);

        // codes 6,7 rejected, 3 accepted and launched on the next edge
        finish_obstacle(3'd6);
        step(4);
        chk("in_sample_busy", busy, 1);
        step(1);
        chk("rej6_no_strobe", strobe, 0);
        code = 3'd7;
        step(1);
        chk("rej7_no_strobe", strobe, 0);
        code = 3'd3;
        step(1);
        chk("accept3_strobe", strobe, 1);
        chk("accept3_sel", sel, 3);
        chk("count_2", count, 2);

        // repeat of 3 held: 4 gap + 1 + 8 rejects -> forced 4
        finish_obstacle(3'd3);
        wait_strobe(40, k);
        chk("force_lat", k, 12);
        chk("force_sel_4", sel, 4);

        // last=4, 4 held -> forced wraps to 0
        finish_obstacle(3'd4);
        wait_strobe(40, k);
        chk("force_wrap_lat", k, 12);
        chk("force_sel_0", sel, 0);
        chk("count_4", count, 4);

        // stop on the edge that would launch: no strobe, IDLE, values held
        finish_obstacle(3'd2);
        chk("count_5", count, 5);
        step(4);
        stop_i = 1'b1;
        step(1);
        chk("stop_strobe", strobe, 0);
        chk("stop_busy", busy, 0);
        chk("stop_en", lfsr_en, 0);
        chk("stop_count_held", count, 5);
        chk("stop_sel_held", sel, 0);
        stop_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen = seen | strobe | busy;
        end
        chk("post_stop_quiet", seen, 0);

        // start+stop together stays idle; plain start clears count
        start_i = 1'b1; stop_i = 1'b1;
        step(1);
        chk("start_stop_idle", busy, 0);
        chk("start_stop_count", count, 5);
        stop_i = 1'b0;
        step(1);
        start_i = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_count", count, 0);

        // 300 completions: saturates at 255
        tmo = 0;
        code = 3'd0;
        for (int i = 0; i < 300; i++) begin
            wait_strobe(40, k);
            if (k >= 40) tmo++;
            finish_obstacle(3'((i + 1) % 5));
            if (i == 254) chk("count_255", count, 255);
        end
        chk("sat_timeouts", tmo, 0);
        chk("count_sat", count, 255);

        // reset while the strobe is high clears everything
        wait_strobe(40, k);
        chk("pre_rst_strobe", strobe, 1);
        rst = 1'b1;
        step(1);
        chk("rst_mid_strobe", strobe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_en", lfsr_en, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_sel", sel, 0);
        rst = 1'b0;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
